// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard-unit controls, Execute redirect inputs,
// instruction-memory handshake and the IF/ID register outputs.
interface fetch_stage_if;
  logic [1:0]  PCSrc;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrF;
  logic        ImemReady;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        RedirectF;

  // Environment side: Execute, hazard unit and instruction memory.
  modport master (
    output PCSrc, PCTargetE, ALUResultE, StallF, StallD, FlushD, InstrF, ImemReady,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectF
  );

  // Fetch stage side.
  modport slave (
    input  PCSrc, PCTargetE, ALUResultE, StallF, StallD, FlushD, InstrF, ImemReady,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, RedirectF
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC register with branch/jalr redirect, stall and memory-wait
// handling, plus the IF/ID pipeline register with bubble/hold control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic [31:0] pc_d, pc_q;
  ifid_t       ifid_d, ifid_q;

  // Decode the branch select; 11 is reserved and behaves as sequential.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = bus.PCTargetE;
    case (bus.PCSrc)
      2'b01: redirect = 1'b1;
      2'b10: begin
        redirect        = 1'b1;
        redirect_target = {bus.ALUResultE[31:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;

  // Next PC: a redirect always wins so it is never lost to a stall or memory wait.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect)                           pc_d = redirect_target;
    else if (bus.StallF || !bus.ImemReady)  pc_d = pc_q;
  end

  // Next IF/ID contents: flush/redirect bubble beats stall, stall beats memory wait.
  always_comb begin
    ifid_d = '{instr: bus.InstrF, pc: pc_q, pc_plus4: pc_plus4, valid: 1'b1};
    if (bus.FlushD || redirect) ifid_d = BUBBLE;
    else if (bus.StallD)        ifid_d = ifid_q;
    else if (!bus.ImemReady)    ifid_d = BUBBLE;
  end

  // State registers with synchronous active-low reset.
  // NOTE: non-blocking assignments here so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= BUBBLE;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign bus.PCF       = pc_q;
  assign bus.InstrD    = ifid_q.instr;
  assign bus.PCD       = ifid_q.pc;
  assign bus.PCPlus4D  = ifid_q.pc_plus4;
  assign bus.ValidD    = ifid_q.valid;
  assign bus.RedirectF = redirect;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: each step drives one cycle of inputs,
// pushes the expected post-edge state to a scoreboard, then pops and compares.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {D_BUB, D_CAP, D_HOLD} d_kind_t;

  typedef struct {
    string       tag;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  fetch_stage_if bus ();

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t last_d;

  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Instruction memory model: a distinct, non-NOP word per address.
  function automatic logic [31:0] imem(input logic [31:0] pc);
    return {pc[23:0], 8'h33};
  endfunction

  assign bus.InstrF = imem(bus.PCF);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst_v, input logic [1:0] src,
                      input logic [31:0] tgt, input logic [31:0] alu,
                      input logic sf, input logic sd, input logic fd, input logic rdy,
                      input logic exp_redir, input logic [31:0] exp_pcf,
                      input d_kind_t dk, input logic [31:0] cap_pc);
    exp_t e;
    rst            = rst_v;
    bus.PCSrc      = src;
    bus.PCTargetE  = tgt;
    bus.ALUResultE = alu;
    bus.StallF     = sf;
    bus.StallD     = sd;
    bus.FlushD     = fd;
    bus.ImemReady  = rdy;
    #1;
    check({tag, ".RedirectF"}, {31'b0, bus.RedirectF}, {31'b0, exp_redir});
    e.tag = tag;
    e.pcf = exp_pcf;
    case (dk)
      D_BUB:  begin e.instr = NOP; e.pcd = 32'h0; e.pc4d = 32'h0; e.valid = 1'b0; end
      D_CAP:  begin e.instr = imem(cap_pc); e.pcd = cap_pc; e.pc4d = cap_pc + 32'd4; e.valid = 1'b1; end
      default: begin e.instr = last_d.instr; e.pcd = last_d.pcd; e.pc4d = last_d.pc4d; e.valid = last_d.valid; end
    endcase
    last_d = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".PCF"},      bus.PCF,      e.pcf);
    check({e.tag, ".InstrD"},   bus.InstrD,   e.instr);
    check({e.tag, ".PCD"},      bus.PCD,      e.pcd);
    check({e.tag, ".PCPlus4D"}, bus.PCPlus4D, e.pc4d);
    check({e.tag, ".ValidD"},   {31'b0, bus.ValidD}, {31'b0, e.valid});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset while a redirect and stall are requested: both discarded.
    step("rst0", 0, 2'b01, 32'h500, 32'h0, 1, 0, 0, 1, 1, 32'h0, D_BUB, 32'h0);
    step("rst1", 0, 2'b01, 32'h500, 32'h0, 1, 1, 0, 0, 1, 32'h0, D_BUB, 32'h0);
    // Sequential fetch; first post-reset edge captures RESET_PC.
    step("seq0", 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h4,  D_CAP, 32'h0);
    step("seq1", 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h8,  D_CAP, 32'h4);
    step("seq2", 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'hC,  D_CAP, 32'h8);
    step("seq3", 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h10, D_CAP, 32'hC);
    // Branch with StallF in the same cycle: redirect still taken, one bubble.
    step("br0", 1, 2'b01, 32'h100, 32'h0, 1, 0, 0, 1, 1, 32'h100, D_BUB, 32'h0);
    step("br1", 1, 2'b00, 32'h0,   32'h0, 0, 0, 0, 1, 0, 32'h104, D_CAP, 32'h100);
    // Jalr clears bit 0; reserved select acts as sequential.
    step("jr0",  1, 2'b10, 32'h0, 32'h203, 0, 0, 0, 1, 1, 32'h202, D_BUB, 32'h0);
    step("jr1",  1, 2'b00, 32'h0, 32'h0,   0, 0, 0, 1, 0, 32'h206, D_CAP, 32'h202);
    step("rsv",  1, 2'b11, 32'h900, 32'h901, 0, 0, 0, 1, 0, 32'h20A, D_CAP, 32'h206);
    // Memory wait at PCF=8: three bubbles, PC held, then capture at 8.
    step("mw_go", 1, 2'b01, 32'h8, 32'h0, 0, 0, 0, 1, 1, 32'h8, D_BUB, 32'h0);
    for (int i = 0; i < 3; i++)
      step($sformatf("mw%0d", i), 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h8, D_BUB, 32'h0);
    step("mw_rdy", 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'hC, D_CAP, 32'h8);
    // StallF only: PC held, D recaptures the same instruction.
    step("sf0", 1, 2'b00, 32'h0, 32'h0, 1, 0, 0, 1, 0, 32'hC,  D_CAP, 32'hC);
    step("sf1", 1, 2'b00, 32'h0, 32'h0, 1, 0, 0, 1, 0, 32'hC,  D_CAP, 32'hC);
    step("sf2", 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h10, D_CAP, 32'hC);
    // StallD holds across two edges, then flush overrides stall.
    step("sd0", 1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 1, 0, 32'h14, D_HOLD, 32'h0);
    step("sd1", 1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 1, 0, 32'h18, D_HOLD, 32'h0);
    step("fl",  1, 2'b00, 32'h0, 32'h0, 0, 1, 1, 1, 0, 32'h1C, D_BUB,  32'h0);
    // StallD has priority over a memory-wait bubble.
    step("sdw0", 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h20, D_CAP,  32'h1C);
    step("sdw1", 1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h20, D_HOLD, 32'h0);
    // PC wrap at the top of the address space.
    step("wr0", 1, 2'b01, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, D_BUB, 32'h0);
    step("wr1", 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0, D_CAP, 32'hFFFF_FFFC);
    // Redirects during memory wait and during all stalls are still applied.
    step("rdw", 1, 2'b01, 32'h300, 32'h0,   0, 0, 0, 0, 1, 32'h300, D_BUB, 32'h0);
    step("rds", 1, 2'b10, 32'h0,   32'h401, 1, 1, 0, 0, 1, 32'h400, D_BUB, 32'h0);
    step("rdn", 1, 2'b00, 32'h0,   32'h0,   0, 0, 0, 1, 0, 32'h404, D_CAP, 32'h400);
    // Reset mid-redirect discards the target; clean restart from RESET_PC.
    step("mrst0", 0, 2'b01, 32'h700, 32'h0, 0, 0, 0, 1, 1, 32'h0, D_BUB, 32'h0);
    step("mrst1", 1, 2'b00, 32'h0,   32'h0, 0, 0, 0, 1, 0, 32'h4, D_CAP, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
